reaction_timer_core: RTL and testbench
======================================

Name: reaction_timer_core

Overview:
- Parametrised successor to the team's reaction-timer block.
- On `start`, waits a pseudo-random delay, then lights `led` and counts milliseconds until the player's button press.
- Reports the result in ms and flags early (before-LED) presses and slow (over-limit) responses.
- Fully synchronous to `clk`; sits between the debounced front-panel button/start inputs and the display/score logic.

Parameters:
- TICK_DIV, 50000, clk cycles per 1 ms tick (use 4 in simulation).
- CNT_W, 12, width of the ms counter and the `rtime` output.
- MAX_MS, 2000, response limit in ms; must be < 2**CNT_W.
- DLY_MIN_MS, 1000, minimum random pre-LED delay in ms.
- DLY_RND_W, 10, random delay extension width; delay = DLY_MIN_MS + lfsr[DLY_RND_W-1:0] ms.
- LFSR_SEED, 16'hACE1, non-zero reset seed of the 16-bit LFSR.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  level/pulse request to begin a trial; sampled synchronously
- btn  in  1  player button, asynchronous; internally 2-flop synchronised
- led  out  1  stimulus lamp; high only in ARMED
- busy  out  1  high in WAIT or ARMED
- rtime  out  CNT_W  last result in ms; holds until next result
- valid  out  1  one-cycle pulse when rtime/slow/early are updated
- slow  out  1  last trial exceeded MAX_MS
- early  out  1  last trial: button pressed before LED

Behaviour:
- Reset (async assert, sync release): state=IDLE, led=0, busy=0, rtime=0, valid=0, slow=0, early=0, ms counter=0, tick prescaler=0, LFSR=LFSR_SEED, sync flops=0.
- Button path: 2-flop synchroniser, then rising-edge detect (press = sync_q & ~sync_q_d).
  - Press is visible 3 clk after the `btn` edge.
  - A held button produces no further presses.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk in all states, so the delay depends on when `start` arrives.
- Tick generator: `tick` pulses 1 clk every TICK_DIV clk. It is cleared when entering WAIT or ARMED, so the first tick comes TICK_DIV clk after entry.
- IDLE:
  - start=1 → WAIT; load delay counter = DLY_MIN_MS + lfsr[DLY_RND_W-1:0].
  - A press in IDLE is ignored.
- WAIT (busy=1, led=0):
  - Delay counter decrements on each tick; reaching 0 → ARMED.
  - A press → DONE with early=1, slow=0, rtime=0.
  - If the press and the final tick occur in the same clk, the press wins (early).
- ARMED (led=1, busy=1):
  - ms counter cleared on entry, +1 per tick.
  - A press → DONE with rtime=ms counter, early=0, slow=0.
  - ms counter reaches MAX_MS without a press → DONE with rtime=MAX_MS (saturated), slow=1.
  - If the press and the tick that reaches MAX_MS occur in the same clk, the press wins: rtime=MAX_MS-1+... is not used; rtime = counter value before the tick, slow=0.
- DONE (1 clk): valid=1, led=0, busy=0 → IDLE.
- rtime/slow/early are registered and stable from the valid cycle until the next valid.
- `start` while busy is ignored; there is no abort input.
- Async reset mid-trial returns to IDLE immediately with all outputs cleared.
- Arithmetic is unsigned, CNT_W bits. The counter never wraps because it saturates at MAX_MS.

Optional Feature:
- BEST_TIME_EN defined:
  - Adds output `best_ms` [CNT_W-1:0], reset to all-ones.
  - On each valid with early=0 and slow=0, best_ms <= min(best_ms, rtime), updated in the same cycle that valid is asserted.
  - Adds input `best_clr`; synchronous, sets best_ms to all-ones.
- Not defined: no best_ms/best_clr ports and no extra registers.

Decomposition:
- Package rt_pkg:
  - state enum (IDLE, WAIT, ARMED, DONE), 2 bits.
  - LFSR tap constant.
  - Default TICK_DIV/MAX_MS constants.
- Sub-module ms_tick_gen: prescaler with params TICK_DIV; ports clk, rst, clr, tick. Reused by the display-refresh logic.

Test Plan (TICK_DIV=4, MAX_MS=20, DLY_MIN_MS=5, DLY_RND_W=2):
- Reset mid-ARMED → same-cycle led=0, busy=0, rtime=0, state IDLE; the next start runs normally.
- start, wait for led, press after 7 ticks → valid pulse, rtime=7, slow=0, early=0; led drops on the valid cycle.
- start, press before led → valid, early=1, rtime=0; led never asserts.
- start, no press → after 20 ticks in ARMED: valid, rtime=20, slow=1.
- Press aligned with the 20th tick → rtime=19, slow=0; press aligned with the last WAIT tick → early=1.
- BEST_TIME_EN: results 9, 6, early, 12 → best_ms = 9, then 6, then 6, then 6; best_clr → all-ones.

Source files
------------

// File: rtl/rt_pkg.sv
// Shared definitions for the reaction-timer slice.
//   rt_state_e  : trial sequencer states (IDLE, WAIT, ARMED, DONE)
//   LFSR_TAPS   : 16-bit Fibonacci taps 16,14,13,11 as a bit mask
//   lfsr_next() : one LFSR step
//   DEF_*       : production defaults for tick divider and response limit
package rt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ARMED = 2'd2,
        DONE  = 2'd3
    } rt_state_e;

    // Tap n maps to bit n-1: bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned DEF_TICK_DIV = 50000;
    localparam int unsigned DEF_MAX_MS   = 2000;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV clk cycles.
//   clk  : system clock
//   rst  : asynchronous active-high reset (prescaler to 0)
//   clr  : synchronous restart; the next tick follows TICK_DIV cycles later
//   tick : one-cycle pulse
module ms_tick_gen
    import rt_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    // tick is not masked by clr: the sequencer may use the same tick that
    // triggers its own state change (and thus the clear).
    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/reaction_timer_core.sv
// Reaction timer: after start, waits a pseudo-random delay, lights led and
// measures the time in ms until the button is pressed.
//   clk, rst : system clock, asynchronous active-high reset
//   start    : begin a trial (ignored while busy)
//   btn      : asynchronous player button, synchronised internally
//   led      : stimulus lamp, high in ARMED
//   busy     : high in WAIT or ARMED
//   rtime    : last result in ms, held until the next result
//   valid    : one-cycle pulse when rtime/slow/early update
//   slow     : last trial hit the MAX_MS limit
//   early    : last trial pressed before the lamp
// Optional (macro BEST_TIME_EN):
//   best_clr : synchronous reset of best_ms to all-ones
//   best_ms  : fastest valid (non-early, non-slow) result
module reaction_timer_core
    import rt_pkg::*;
#(
    parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned MAX_MS     = DEF_MAX_MS,
    parameter int unsigned DLY_MIN_MS = 1000,
    parameter int unsigned DLY_RND_W  = 10,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             btn,
    output logic             led,
    output logic             busy,
    output logic [CNT_W-1:0] rtime,
    output logic             valid,
    output logic             slow,
    output logic             early
`ifdef BEST_TIME_EN
    ,
    input  logic             best_clr,
    output logic [CNT_W-1:0] best_ms
`endif
);

    localparam int unsigned DLY_RAW = $clog2(DLY_MIN_MS + (2 ** DLY_RND_W));
    localparam int unsigned DLY_W   = (DLY_RAW > 0) ? DLY_RAW : 1;

    rt_state_e        state, state_next;
    logic [15:0]      lfsr;
    logic [DLY_W-1:0] dly, dly_next;
    logic [CNT_W-1:0] ms, ms_next;
    logic             sync1, sync_q, sync_q_d;
    logic             press;
    logic             tick, tick_clr;

    logic             res_load;
    logic [CNT_W-1:0] res_rtime;
    logic             res_slow, res_early;

    assign press = sync_q & ~sync_q_d;
    assign led   = (state == ARMED);
    assign busy  = (state == WAIT) || (state == ARMED);
    assign valid = (state == DONE);

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_comb begin
        state_next = state;
        dly_next   = dly;
        ms_next    = ms;
        res_load   = 1'b0;
        res_rtime  = '0;
        res_slow   = 1'b0;
        res_early  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WAIT;
                    dly_next   = DLY_W'(DLY_MIN_MS) + DLY_W'(lfsr[DLY_RND_W-1:0]);
                end
            end
            WAIT: begin
                // A press in the same cycle as the final delay tick counts as early.
                if (press) begin
                    state_next = DONE;
                    res_load   = 1'b1;
                    res_early  = 1'b1;
                end else if (tick) begin
                    if (dly <= DLY_W'(1)) begin
                        state_next = ARMED;
                        dly_next   = '0;
                        ms_next    = '0;
                    end else begin
                        dly_next = dly - DLY_W'(1);
                    end
                end
            end
            ARMED: begin
                // Press beats the limit tick; rtime is the pre-tick count.
                if (press) begin
                    state_next = DONE;
                    res_load   = 1'b1;
                    res_rtime  = ms;
                end else if (tick) begin
                    if (ms == CNT_W'(MAX_MS - 1)) begin
                        state_next = DONE;
                        res_load   = 1'b1;
                        res_rtime  = CNT_W'(MAX_MS);
                        res_slow   = 1'b1;
                    end else begin
                        ms_next = ms + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
        endcase

        tick_clr = (state_next != state) &&
                   ((state_next == WAIT) || (state_next == ARMED));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lfsr     <= LFSR_SEED;
            dly      <= '0;
            ms       <= '0;
            sync1    <= 1'b0;
            sync_q   <= 1'b0;
            sync_q_d <= 1'b0;
            rtime    <= '0;
            slow     <= 1'b0;
            early    <= 1'b0;
        end else begin
            state    <= state_next;
            lfsr     <= lfsr_next(lfsr);
            dly      <= dly_next;
            ms       <= ms_next;
            sync1    <= btn;
            sync_q   <= sync1;
            sync_q_d <= sync_q;
            if (res_load) begin
                rtime <= res_rtime;
                slow  <= res_slow;
                early <= res_early;
            end
        end
    end

`ifdef BEST_TIME_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_ms <= '1;
        end else if (best_clr) begin
            best_ms <= '1;
        end else if (res_load && !res_slow && !res_early && (res_rtime < best_ms)) begin
            best_ms <= res_rtime;
        end
    end
`endif

endmodule

// File: tb/tb_reaction_timer_core.sv
// Scoreboard bench for reaction_timer_core (small simulation parameters).
// Expected results are derived from trial timing: the start edge, the
// delay taken from a reference LFSR, and the planned button edge.
module tb_reaction_timer_core;

    localparam int TICK = 4;
    localparam int MAXM = 20;
    localparam int DMIN = 5;
    localparam int RW   = 2;
    localparam int CW   = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst, start, btn;
    logic          led, busy, valid, slow, early;
    logic [CW-1:0] rtime;
`ifdef BEST_TIME_EN
    logic          best_clr;
    logic [CW-1:0] best_ms;
`endif

    always #5 clk = ~clk;

    reaction_timer_core #(
        .TICK_DIV   (TICK),
        .CNT_W      (CW),
        .MAX_MS     (MAXM),
        .DLY_MIN_MS (DMIN),
        .DLY_RND_W  (RW),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .btn      (btn),
        .led      (led),
        .busy     (busy),
        .rtime    (rtime),
        .valid    (valid),
        .slow     (slow),
        .early    (early)
`ifdef BEST_TIME_EN
        ,
        .best_clr (best_clr),
        .best_ms  (best_ms)
`endif
    );

    typedef struct {
        int rtime;
        bit slow;
        bit early;
        int best;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          ec = 0;
    int          m_best = (1 << CW) - 1;
    logic [15:0] m_lfsr;

    // Reference LFSR: Fibonacci, taps 16,14,13,11, stepping every clock.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    always @(posedge clk) ec <= ec + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid pulse consumes one expected result.
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rtime", int'(rtime), e.rtime);
                chk("slow", int'(slow), int'(e.slow));
                chk("early", int'(early), int'(e.early));
                chk("led_on_valid", int'(led), 0);
                chk("busy_on_valid", int'(busy), 0);
`ifdef BEST_TIME_EN
                chk("best_ms", int'(best_ms), e.best);
`endif
            end
        end
    end

    // One trial. off = button-press edge relative to the LED-on edge
    // (<=0 means early); press=0 means no press at all.
    task automatic run_trial(input int off, input bit press);
        int   d, s, a, pe, led_seen;
        exp_t e;
        d  = DMIN + (int'(m_lfsr) % (1 << RW));
        start = 1'b1;
        s  = ec + 1;
        a  = s + TICK * d;
        pe = a + off;
        e.slow = 1'b0; e.early = 1'b0; e.rtime = 0;
        if (press && pe <= a) begin
            e.early = 1'b1;
        end else if (press && pe <= a + TICK * MAXM) begin
            e.rtime = (pe - a - 1) / TICK;
        end else begin
            e.slow  = 1'b1;
            e.rtime = MAXM;
        end
        if (!e.slow && !e.early && e.rtime < m_best) m_best = e.rtime;
        e.best = m_best;
        q.push_back(e);
        led_seen = 0;
        step();
        start = 1'b0;
        chk("busy_in_wait", int'(busy), 1);
        chk("led_in_wait", int'(led), 0);
        for (int i = 0; i < TICK * (d + MAXM) + 30; i++) begin
            start = (ec == s + 1);   // start while busy must be ignored
            if (press && ec == pe - 3) btn = 1'b1;
            if (!e.early && ec == a) chk("led_on_arm", int'(led), 1);
            if (e.early && led) led_seen = 1;
            if (q.size() == 0) break;
            step();
        end
        if (q.size() != 0) begin
            chk("result_timeout", 1, 0);
            q.delete();
        end
        if (e.early) chk("led_never_on", led_seen, 0);
        start = 1'b0;
        btn   = 1'b0;
        repeat (6) step();
    endtask

    // Start a trial with no press, reset asynchronously while ARMED.
    task automatic abort_armed();
        int d, s, a;
        d = DMIN + (int'(m_lfsr) % (1 << RW));
        start = 1'b1;
        s = ec + 1;
        a = s + TICK * d;
        step();
        start = 1'b0;
        while (ec < a + 10) step();
        chk("led_before_abort", int'(led), 1);
        #1 rst = 1'b1;
        #1;
        chk("abort_led", int'(led), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rtime", int'(rtime), 0);
        chk("abort_valid", int'(valid), 0);
        chk("abort_slow", int'(slow), 0);
`ifdef BEST_TIME_EN
        chk("abort_best", int'(best_ms), (1 << CW) - 1);
`endif
        m_best = (1 << CW) - 1;
        step();
        rst = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; btn = 1'b0;
`ifdef BEST_TIME_EN
        best_clr = 1'b0;
`endif
        repeat (3) step();
        chk("rst_led", int'(led), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_rtime", int'(rtime), 0);
        chk("rst_slow", int'(slow), 0);
        chk("rst_early", int'(early), 0);
`ifdef BEST_TIME_EN
        chk("rst_best", int'(best_ms), (1 << CW) - 1);
`endif
        rst = 1'b0;
        repeat (2) step();

        run_trial(TICK * 7 + 1, 1'b1);     // rtime 7
        run_trial(-8, 1'b1);               // early
        run_trial(0, 1'b0);                // no press: slow, 20
        run_trial(TICK * MAXM, 1'b1);      // press on the limit tick: 19
        run_trial(0, 1'b1);                // press on the final WAIT tick: early
        run_trial(TICK * MAXM + 1, 1'b1);  // just too late: slow
        run_trial(1, 1'b1);                // first cycle of ARMED: 0

        abort_armed();
        run_trial(TICK * 7 + 3, 1'b1);     // normal after reset: 7

`ifdef BEST_TIME_EN
        abort_armed();
        run_trial(TICK * 9 + 1, 1'b1);
        run_trial(TICK * 6 + 1, 1'b1);
        run_trial(-4, 1'b1);
        run_trial(TICK * 12 + 1, 1'b1);
        best_clr = 1'b1;
        step();
        best_clr = 1'b0;
        m_best = (1 << CW) - 1;
        chk("best_clr", int'(best_ms), (1 << CW) - 1);
`endif

        for (int n = 0; n < 25; n++) begin
            int  d_lo, off;
            bit  pr;
            d_lo = DMIN + (int'(m_lfsr) % (1 << RW));
            off  = int'($urandom_range(0, TICK * (MAXM + d_lo) + 8)) + 4 - TICK * d_lo;
            pr   = ($urandom_range(0, 5) != 0);
            run_trial(off, pr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
